// File: rtl/rvfi_mem_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style native memory port.
// The grant is registered and held until the slave returns mem_ready.
// Sticky flags report wait-state timeouts and owners dropping valid early.
module rvfi_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout,
    output logic        error
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       error_q, error_d;

    logic       busy;
    logic       sel;
    logic       owner_valid;
    logic [7:0] wait_inc;

    // Output decode; reset gates everything off combinationally so that no
    // ready escapes in the cycle reset is first seen.
    always_comb begin
        busy      = !reset && (state_q == StBusy);
        sel       = reset ? 1'b0 : owner_q;
        mem_valid = busy;
        mem_instr = sel ? m1_instr : m0_instr;
        mem_addr  = sel ? m1_addr  : m0_addr;
        mem_wdata = sel ? m1_wdata : m0_wdata;
        mem_wstrb = sel ? m1_wstrb : m0_wstrb;
        grant     = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        m0_ready  = busy && mem_ready && !owner_q;
        m1_ready  = busy && mem_ready && owner_q;
        m0_rdata  = m0_ready ? mem_rdata : 32'h0;
        m1_rdata  = m1_ready ? mem_rdata : 32'h0;
        timeout   = timeout_q;
        error     = error_q;
    end

    // Next-state: arbitration in IDLE, completion/violation/wait tracking in BUSY.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        error_d     = error_q;
        owner_valid = owner_q ? m1_valid : m0_valid;
        wait_inc    = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        unique case (state_q)
            StIdle: begin
                if (m0_valid || m1_valid) begin
                    state_d    = StBusy;
                    // Contention goes to whoever did not complete last.
                    owner_d    = (m0_valid && m1_valid) ? !last_q : m1_valid;
                    wait_cnt_d = 8'd0;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    state_d    = StIdle;
                    last_d     = owner_q;
                    wait_cnt_d = 8'd0;
                end else if (!owner_valid) begin
                    state_d    = StIdle;
                    error_d    = 1'b1;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == 8'(MAX_WAIT)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; last=1 lets m0 win first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// Bench for rvfi_mem_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_rvfi_mem_arbiter;

    localparam int unsigned MaxWait = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;
    logic        timeout, error;

    int checks = 0;
    int errors = 0;

    rvfi_mem_arbiter #(.MAX_WAIT(MaxWait)) dut (
        .clock(clock), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant(grant), .timeout(timeout), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m0_valid;
        logic        m1_valid;
        logic [31:0] m0_addr;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_wstrb;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_valid;
        logic [1:0]  e_grant;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t       vecs[9];
    logic [1:0] rr_grant[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
    endtask

    // Reference model state: a transaction-level view of the arbiter.
    bit          mdl_busy;
    int          mdl_owner, mdl_last, mdl_waited;
    bit          mdl_to, mdl_err;
    logic        rv[2], rin[2];
    logic [31:0] raddr[2], rwd[2];
    logic [3:0]  rws[2];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b1, 2'b01, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h55AA55AA,
                    1'b1, 2'b01, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                    1'b1, 2'b01, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h100, 32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0,
                    1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h100, 32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0,
                    1'b1, 2'b10, 32'h200, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'h100, 32'h200, 32'h12345678, 4'hF, 1'b1, 32'hCAFEF00D,
                    1'b1, 2'b10, 32'h200, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b0, 32'h100, 32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0,
                    1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        rr_grant = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

        // Reset state.
        do_reset();
        #2;
        check("reset_mem_valid", 32'(mem_valid), 32'h0);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        check("reset_error", 32'(error), 32'h0);

        // Vector table: m0 read completing on 3rd BUSY cycle, then m1 write.
        for (int i = 0; i < 9; i++) begin
            m0_valid = vecs[i].m0_valid; m0_addr = vecs[i].m0_addr;
            m1_valid = vecs[i].m1_valid; m1_addr = vecs[i].m1_addr;
            m1_wdata = vecs[i].m1_wdata; m1_wstrb = vecs[i].m1_wstrb;
            mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
            #2;
            check($sformatf("vec%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
                check($sformatf("vec%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_wstrb));
            end
            check($sformatf("vec%0d_m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_r0));
            check($sformatf("vec%0d_m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_r1));
            check($sformatf("vec%0d_m0_rdata", i), m0_rdata, vecs[i].e_rd0);
            check($sformatf("vec%0d_m1_rdata", i), m1_rdata, vecs[i].e_rd1);
            step();
        end

        // Continuous contention from reset, slave always ready.
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77;
        for (int i = 0; i < 8; i++) begin
            #2;
            check($sformatf("rr%0d_grant", i), 32'(grant), 32'(rr_grant[i]));
            check($sformatf("rr%0d_m0_ready", i), 32'(m0_ready), 32'(rr_grant[i] == 2'b01));
            check($sformatf("rr%0d_m1_ready", i), 32'(m1_ready), 32'(rr_grant[i] == 2'b10));
            step();
        end

        // Slave never ready: timeout after MaxWait BUSY cycles, then reset mid-transaction.
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h300;
        for (int c = 0; c < 9; c++) begin
            #2;
            if (c >= 1) check($sformatf("to%0d_mem_valid", c), 32'(mem_valid), 32'h1);
            check($sformatf("to%0d_timeout", c), 32'(timeout), 32'(c >= 5));
            step();
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        #2;
        check("rst_no_ready", 32'(m0_ready), 32'h0);
        step();
        reset = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        step();

        // Owner drops valid: error, back to IDLE, pending m1 served; reset clears error.
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; m1_addr = 32'h444;
        #2; check("err0_grant", 32'(grant), 32'h0); step();
        #2; check("err1_grant", 32'(grant), 32'h1); step();
        m0_valid = 1'b0;
        #2;
        check("err2_mem_valid", 32'(mem_valid), 32'h1);
        check("err2_error", 32'(error), 32'h0);
        step();
        #2;
        check("err3_error", 32'(error), 32'h1);
        check("err3_mem_valid", 32'(mem_valid), 32'h0);
        step();
        #2;
        check("err4_grant", 32'(grant), 32'h2);
        check("err4_mem_addr", mem_addr, 32'h444);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_valid = 1'b1;
        #2;
        check("err6_mem_valid", 32'(mem_valid), 32'h0);
        check("err6_error", 32'(error), 32'h0);
        step();
        #2; check("err7_grant", 32'(grant), 32'h1); step();

        // Randomized traffic against the reference model.
        do_reset();
        mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_waited = 0; mdl_to = 0; mdl_err = 0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rin[i] = 1'b0; raddr[i] = 32'h0; rwd[i] = 32'h0; rws[i] = 4'h0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       rst, mr;
            logic [31:0] mrd;
            logic       er[2];
            int         sel;
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(0, 9) < 4) begin
                    rv[i] = 1'b1; raddr[i] = $urandom; rwd[i] = $urandom;
                    rws[i] = 4'($urandom); rin[i] = 1'($urandom);
                end
            end
            mr = 1'($urandom);
            mrd = $urandom;
            reset = rst;
            m0_valid = rv[0]; m0_instr = rin[0]; m0_addr = raddr[0]; m0_wdata = rwd[0];
            m0_wstrb = rws[0];
            m1_valid = rv[1]; m1_instr = rin[1]; m1_addr = raddr[1]; m1_wdata = rwd[1];
            m1_wstrb = rws[1];
            mem_ready = mr; mem_rdata = mrd;
            #2;
            er[0] = !rst && mdl_busy && mr && (mdl_owner == 0);
            er[1] = !rst && mdl_busy && mr && (mdl_owner == 1);
            sel = rst ? 0 : mdl_owner;
            check("rnd_mem_valid", 32'(mem_valid), 32'(!rst && mdl_busy));
            check("rnd_grant", 32'(grant), (!rst && mdl_busy) ? (32'h1 << mdl_owner) : 32'h0);
            check("rnd_m0_ready", 32'(m0_ready), 32'(er[0]));
            check("rnd_m1_ready", 32'(m1_ready), 32'(er[1]));
            check("rnd_m0_rdata", m0_rdata, er[0] ? mrd : 32'h0);
            check("rnd_m1_rdata", m1_rdata, er[1] ? mrd : 32'h0);
            check("rnd_timeout", 32'(timeout), 32'(mdl_to));
            check("rnd_error", 32'(error), 32'(mdl_err));
            if (rst || mdl_busy) begin
                check("rnd_mem_addr", mem_addr, raddr[sel]);
                check("rnd_mem_wdata", mem_wdata, rwd[sel]);
                check("rnd_mem_wstrb", 32'(mem_wstrb), 32'(rws[sel]));
                check("rnd_mem_instr", 32'(mem_instr), 32'(rin[sel]));
            end
            // Advance the model by one clock.
            if (rst) begin
                mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_waited = 0;
                mdl_to = 0; mdl_err = 0;
            end else if (!mdl_busy) begin
                if (rv[0] || rv[1]) begin
                    mdl_busy = 1;
                    mdl_owner = (rv[0] && rv[1]) ? (1 - mdl_last) : (rv[1] ? 1 : 0);
                    mdl_waited = 0;
                end
            end else if (mr) begin
                mdl_busy = 0;
                mdl_last = mdl_owner;
                mdl_waited = 0;
                rv[mdl_owner] = 1'b0;
            end else begin
                if (mdl_waited < 255) mdl_waited++;
                if (mdl_waited == int'(MaxWait)) mdl_to = 1;
            end
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
